// File: rtl/light_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module      : light_pwm_driver
// Description : Converts 2-bit luminosity and colour codes into three
//               registered PWM lamp drives with smooth level ramps and
//               fade-out / swap / fade-in colour transitions.
// Revision    : 1.0 - initial release
// ============================================================================
module light_pwm_driver #(
    parameter int PWM_BITS  = 8,
    parameter int FADE_DIV  = 16,
    parameter int LOW_DUTY  = 64,
    parameter int MID_DUTY  = 128,
    parameter int HIGH_DUTY = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          luminosity,
    input  logic [1:0]          color,
    output logic                pwm_r,
    output logic                pwm_g,
    output logic                pwm_b,
    output logic [PWM_BITS-1:0] duty,
    output logic                fading
);

    localparam int PRE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [PRE_W-1:0]    c_pre_last = PRE_W'(FADE_DIV - 1);
    localparam logic [PRE_W-1:0]    c_pre_one  = PRE_W'(1);
    localparam logic [PWM_BITS-1:0] c_cnt_max  = '1;
    localparam logic [PWM_BITS-1:0] c_one      = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] c_low      = PWM_BITS'(LOW_DUTY);
    localparam logic [PWM_BITS-1:0] c_mid      = PWM_BITS'(MID_DUTY);
    localparam logic [PWM_BITS-1:0] c_high     = PWM_BITS'(HIGH_DUTY);

    localparam logic [1:0] c_white = 2'b00;
    localparam logic [1:0] c_red   = 2'b01;
    localparam logic [1:0] c_green = 2'b10;

    typedef enum logic [1:0] {
        ST_STEADY = 2'd0,
        ST_RAMP   = 2'd1,
        ST_SWAP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_lum_q;
    logic [1:0]          r_color_q;
    logic [1:0]          r_active;
    logic [1:0]          w_active_next;
    logic [PRE_W-1:0]    r_pre;
    logic                w_tick;
    logic [PWM_BITS-1:0] r_duty;
    logic [PWM_BITS-1:0] w_duty_next;
    logic [PWM_BITS-1:0] w_target;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_applied;
    logic [2:0]          w_mask;
    logic                r_pwm_r;
    logic                r_pwm_g;
    logic                r_pwm_b;

    // Single register stage on the upstream codes; all decisions use these copies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lum_q   <= 2'b00;
            r_color_q <= c_white;
        end else begin
            r_lum_q   <= luminosity;
            r_color_q <= color;
        end
    end

    // Luminosity code to target duty.
    always_comb begin
        w_target = '0;
        case (r_lum_q)
            2'b01:   w_target = c_low;
            2'b10:   w_target = c_mid;
            2'b11:   w_target = c_high;
            default: w_target = '0;
        endcase
    end

    // Free-running fade prescaler; one tick per FADE_DIV clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
        end else if (r_pre == c_pre_last) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_pre_one;
        end
    end

    assign w_tick = (r_pre == c_pre_last);

    // Fade state register together with the ramping duty and latched colour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_STEADY;
            r_duty   <= '0;
            r_active <= c_white;
        end else begin
            r_state  <= w_state_next;
            r_duty   <= w_duty_next;
            r_active <= w_active_next;
        end
    end

    // Next-state logic: colour mismatch always wins and forces a fade to zero
    // before the new channel mask is taken; duty moves one step per tick.
    always_comb begin
        w_state_next  = r_state;
        w_duty_next   = r_duty;
        w_active_next = r_active;
        case (r_state)
            ST_STEADY: begin
                if (r_color_q != r_active) begin
                    w_state_next = ST_SWAP;
                end else if (r_duty != w_target) begin
                    w_state_next = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (r_color_q != r_active) begin
                    w_state_next = ST_SWAP;
                end else if (r_duty == w_target) begin
                    w_state_next = ST_STEADY;
                end else if (w_tick) begin
                    if (r_duty < w_target) begin
                        w_duty_next = r_duty + c_one;
                    end else begin
                        w_duty_next = r_duty - c_one;
                    end
                end
            end
            ST_SWAP: begin
                if (r_duty == '0) begin
                    w_active_next = r_color_q;
                    w_state_next  = (w_target == '0) ? ST_STEADY : ST_RAMP;
                end else if (w_tick) begin
                    w_duty_next = r_duty - c_one;
                end
            end
            default: begin
                w_state_next = ST_STEADY;
            end
        endcase
    end

    // Channel enables {r,g,b} from the latched colour.
    always_comb begin
        w_mask = 3'b111;
        case (r_active)
            c_white: w_mask = 3'b111;
            c_red:   w_mask = 3'b100;
            c_green: w_mask = 3'b010;
            default: w_mask = 3'b001;
        endcase
    end

    // PWM counter; duty is only sampled at the period boundary so a ramp
    // never truncates or stretches a pulse mid-period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt <= '0;
            r_applied <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + c_one;
            if (r_pwm_cnt == c_cnt_max) begin
                r_applied <= r_duty;
            end
        end
    end

    // Registered lamp drives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_r <= 1'b0;
            r_pwm_g <= 1'b0;
            r_pwm_b <= 1'b0;
        end else begin
            r_pwm_r <= w_mask[2] & (r_pwm_cnt < r_applied);
            r_pwm_g <= w_mask[1] & (r_pwm_cnt < r_applied);
            r_pwm_b <= w_mask[0] & (r_pwm_cnt < r_applied);
        end
    end

    assign pwm_r  = r_pwm_r;
    assign pwm_g  = r_pwm_g;
    assign pwm_b  = r_pwm_b;
    assign duty   = r_duty;
    assign fading = (r_state != ST_STEADY);

endmodule
`default_nettype wire

// File: tb/tb_light_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_light_pwm_driver
// Description : Scoreboard bench for light_pwm_driver. Stimulus queues the
//               expected duty sequence; a monitor pops on each duty change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_light_pwm_driver;

    logic       clk;
    logic       reset;
    logic [1:0] luminosity;
    logic [1:0] color;
    logic       pwm_r;
    logic       pwm_g;
    logic       pwm_b;
    logic [3:0] duty;
    logic       fading;

    int exp_q[$];
    int total = 0;
    int bad   = 0;
    int last_duty = 0;

    light_pwm_driver #(
        .PWM_BITS  (4),
        .FADE_DIV  (2),
        .LOW_DUTY  (4),
        .MID_DUTY  (8),
        .HIGH_DUTY (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .luminosity (luminosity),
        .color      (color),
        .pwm_r      (pwm_r),
        .pwm_g      (pwm_g),
        .pwm_b      (pwm_b),
        .duty       (duty),
        .fading     (fading)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every observed duty change must match the head of the queue.
    always @(negedge clk) begin
        if (reset) begin
            last_duty = 0;
        end else if (int'(duty) != last_duty) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL duty_seq: got %0d, nothing expected", duty);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(duty) != e) begin
                    bad++;
                    $display("FAIL duty_seq: got %0d expected %0d", duty, e);
                end
            end
            last_duty = int'(duty);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_range(input int a, input int b);
        if (a <= b) begin
            for (int v = a; v <= b; v++) exp_q.push_back(v);
        end else begin
            for (int v = a; v >= b; v--) exp_q.push_back(v);
        end
    endtask

    // Wait for the scoreboard to empty; also count clocks mid-transition
    // where fading dropped although steps were still outstanding.
    task automatic wait_drain(input string name, input int budget);
        int n;
        int gaps;
        int start;
        bit armed;
        n = 0; gaps = 0; armed = 1'b0; start = int'(duty);
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            if (int'(duty) != start) armed = 1'b1;
            if (armed && duty != 4'd0 && exp_q.size() != 0 && !fading) gaps++;
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_fading_gaps"}, gaps, 0);
        exp_q.delete();
    endtask

    task automatic wait_duty(input string name, input int val, input int budget,
                             output int g_seen);
        int n;
        n = 0; g_seen = 0;
        while (int'(duty) != val && n < budget) begin
            @(negedge clk);
            #1;
            if (pwm_g) g_seen++;
            n++;
        end
        check({name, "_reach"}, int'(duty), val);
    endtask

    task automatic measure(input int len, output int r, output int g,
                           output int b, output int diff);
        r = 0; g = 0; b = 0; diff = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (pwm_r) r++;
            if (pwm_g) g++;
            if (pwm_b) b++;
            if (pwm_r != pwm_g || pwm_g != pwm_b) diff++;
        end
    endtask

    task automatic settle();
        repeat (40) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, g, b, diff, gs;

        // 1: reset held with HIGH requested, then ramp up from zero
        reset = 1'b1; luminosity = 2'b11; color = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        check("t1_rst_duty", int'(duty), 0);
        check("t1_rst_pwm", int'({pwm_r, pwm_g, pwm_b}), 0);
        check("t1_rst_fading", int'(fading), 0);
        reset = 1'b0;
        push_range(1, 15);
        wait_drain("t1", 200);
        repeat (3) @(negedge clk);
        #1;
        check("t1_final_duty", int'(duty), 15);
        check("t1_final_fading", int'(fading), 0);

        // 2: steady MID white, each channel high 8 of every 16 clocks
        luminosity = 2'b10;
        push_range(14, 8);
        wait_drain("t2", 200);
        settle();
        measure(16, r, g, b, diff);
        check("t2_r_high", r, 8);
        check("t2_g_high", g, 8);
        check("t2_b_high", b, 8);
        check("t2_rgb_diff", diff, 0);

        // 3: HIGH white, then colour to RED: fade out, swap, fade in
        luminosity = 2'b11;
        push_range(9, 15);
        wait_drain("t3a", 200);
        color = 2'b01;
        push_range(14, 0);
        push_range(1, 15);
        wait_duty("t3_zero", 0, 200, gs);
        check("t3_green_lit_before_swap", int'(gs > 0), 1);
        wait_drain("t3b", 200);
        settle();
        measure(16, r, g, b, diff);
        check("t3_r_high", r, 15);
        check("t3_g_high", g, 0);
        check("t3_b_high", b, 0);

        // 4: reversal mid-ramp, 10 back down to LOW=4 with no overshoot
        luminosity = 2'b00;
        push_range(14, 0);
        wait_drain("t4a", 200);
        luminosity = 2'b11;
        push_range(1, 10);
        wait_duty("t4_ten", 10, 200, gs);
        luminosity = 2'b01;
        push_range(9, 4);
        wait_drain("t4b", 200);
        repeat (10) @(negedge clk);
        #1;
        check("t4_duty", int'(duty), 4);
        check("t4_fading", int'(fading), 0);

        // 5: back to white, then RED followed by BLUE during the fade-out
        color = 2'b00;
        push_range(3, 0);
        push_range(1, 4);
        wait_drain("t5a", 200);
        color = 2'b01;
        push_range(3, 0);
        push_range(1, 4);
        wait_duty("t5_two", 2, 200, gs);
        color = 2'b11;
        wait_drain("t5b", 200);
        settle();
        measure(16, r, g, b, diff);
        check("t5_r_high", r, 0);
        check("t5_g_high", g, 0);
        check("t5_b_high", b, 4);
        luminosity = 2'b00;
        push_range(3, 0);
        wait_drain("t5c", 200);
        settle();
        measure(32, r, g, b, diff);
        check("t5_off_pwm", r + g + b, 0);
        check("t5_off_duty", int'(duty), 0);

        // 6: asynchronous reset in the middle of a ramp
        luminosity = 2'b11;
        push_range(1, 7);
        wait_duty("t6_seven", 7, 200, gs);
        #1;
        reset = 1'b1;
        #1;
        check("t6_async_duty", int'(duty), 0);
        check("t6_async_pwm", int'({pwm_r, pwm_g, pwm_b}), 0);
        check("t6_async_fading", int'(fading), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        push_range(1, 15);
        wait_drain("t6", 200);
        settle();
        measure(16, r, g, b, diff);
        check("t6_r_high", r, 0);
        check("t6_b_high", b, 15);
        check("t6_fading", int'(fading), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
